param_queue: RTL and testbench



---
 rtl/param_queue.sv | 107 ++++++++++
 tb/tb_param_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/param_queue.sv
// param_queue: parametrised same-clock FIFO with first-word fall-through or
// registered read, occupancy thresholds, flush and sticky error flags.
module param_queue #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter bit FWFT      = 1'b1
) (
    input  logic                   wb_clk_i,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    output logic                   full,
    output logic                   afull,
    input  logic                   pop,
    output logic [DATA_W-1:0]      pop_data,
    output logic                   pop_valid,
    output logic                   empty,
    output logic                   aempty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic                   udf,
    input  logic                   err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              pop_acc;
    logic              push_acc;
    logic              ovf_ev;
    logic              udf_ev;

    // Flags come only from the registered count, never from push/pop.
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign afull  = (32'(count) >= 32'(AFULL_TH));
    assign aempty = (32'(count) <= 32'(AEMPTY_TH));

    assign pop_acc  = pop & ~empty & ~clr;
    assign push_acc = push & ~clr & (~full | pop_acc);
    assign ovf_ev   = push & ~clr & ~push_acc;
    assign udf_ev   = pop & ~clr & empty;

    always_ff @(posedge wb_clk_i) begin
        if (rst_n && push_acc) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            ovf <= (ovf & ~err_clr) | ovf_ev;
            udf <= (udf & ~err_clr) | udf_ev;
            if (clr) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (pop_acc) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push_acc) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                count <= count + CW'(push_acc) - CW'(pop_acc);
            end
        end
    end

    if (FWFT) begin : g_fwft
        assign pop_data  = mem[rd_ptr];
        assign pop_valid = ~empty;
    end else begin : g_reg
        logic [DATA_W-1:0] data_q;
        logic              valid_q;

        // The head is captured on the same edge the pointer moves past it.
        always_ff @(posedge wb_clk_i) begin
            if (!rst_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (clr) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= pop_acc;
                if (pop_acc) begin
                    data_q <= mem[rd_ptr];
                end
            end
        end

        assign pop_data  = data_q;
        assign pop_valid = valid_q;
    end

endmodule

// File: tb/tb_param_queue.sv
// tb_param_queue: vector table and scoreboard for a 16-deep FWFT queue,
// hand sequences for a 4-deep registered-read queue.
module tb_param_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_clr, a_push, a_pop, a_ec;
    logic [31:0] a_pd, a_qd;
    logic        a_full, a_afull, a_pv, a_empty, a_aempty, a_ovf, a_udf;
    logic [4:0]  a_cnt;

    logic        b_clr, b_push, b_pop, b_ec;
    logic [7:0]  b_pd, b_qd;
    logic        b_full, b_afull, b_pv, b_empty, b_aempty, b_ovf, b_udf;
    logic [2:0]  b_cnt;

    param_queue u_a (
        .wb_clk_i(clk), .rst_n(rst_n), .clr(a_clr),
        .push(a_push), .push_data(a_pd), .full(a_full), .afull(a_afull),
        .pop(a_pop), .pop_data(a_qd), .pop_valid(a_pv), .empty(a_empty),
        .aempty(a_aempty), .count(a_cnt), .ovf(a_ovf), .udf(a_udf),
        .err_clr(a_ec)
    );

    param_queue #(.DATA_W(8), .DEPTH(4), .FWFT(1'b0)) u_b (
        .wb_clk_i(clk), .rst_n(rst_n), .clr(b_clr),
        .push(b_push), .push_data(b_pd), .full(b_full), .afull(b_afull),
        .pop(b_pop), .pop_data(b_qd), .pop_valid(b_pv), .empty(b_empty),
        .aempty(b_aempty), .count(b_cnt), .ovf(b_ovf), .udf(b_udf),
        .err_clr(b_ec)
    );

    typedef struct {
        logic        push, pop, clr, ec;
        logic [31:0] d;
        int          cnt;
        logic        full, afull, empty, aempty, ovf, udf;
    } vec_t;

    vec_t        tv[$];
    logic [31:0] qa[$];
    logic [7:0]  qb[$];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic pu, input logic po, input logic cl,
                                input logic ec, input logic [31:0] d,
                                input int c, input logic ov, input logic ud);
        vec_t v;
        v.push = pu; v.pop = po; v.clr = cl; v.ec = ec; v.d = d;
        v.cnt = c; v.ovf = ov; v.udf = ud;
        v.full = (c == 16);
        v.afull = (c >= 14);
        v.empty = (c == 0);
        v.aempty = (c <= 2);
        return v;
    endfunction

    task automatic step_a(input vec_t v, input int idx);
        logic pa, wa;
        @(negedge clk);
        a_push = v.push; a_pop = v.pop; a_clr = v.clr; a_ec = v.ec; a_pd = v.d;
        #1;
        if (v.pop && !v.clr && qa.size() > 0)
            chk($sformatf("a_data[%0d]", idx), a_qd, qa[0]);
        @(posedge clk);
        pa = v.pop && !v.clr && qa.size() > 0;
        wa = v.push && !v.clr && (qa.size() < 16 || pa);
        if (v.clr) qa.delete();
        else begin
            if (pa) void'(qa.pop_front());
            if (wa) qa.push_back(v.d);
        end
        #1;
        chk($sformatf("a_count[%0d]", idx), 32'(a_cnt), 32'(v.cnt));
        chk($sformatf("a_flags[%0d]", idx),
            32'({a_full, a_afull, a_empty, a_aempty, a_ovf, a_udf, a_pv}),
            32'({v.full, v.afull, v.empty, v.aempty, v.ovf, v.udf, !v.empty}));
    endtask

    task automatic step_b(input logic pu, input logic [7:0] d, input logic po);
        logic       pb, wb, ev;
        logic [7:0] ed;
        @(negedge clk);
        b_push = pu; b_pd = d; b_pop = po;
        @(posedge clk);
        pb = po && qb.size() > 0;
        wb = pu && (qb.size() < 4 || pb);
        ev = pb;
        ed = 8'h00;
        if (pb) ed = qb.pop_front();
        if (wb) qb.push_back(d);
        #1;
        chk("b_valid", 32'(b_pv), 32'(ev));
        if (ev) chk("b_data", 32'(b_qd), 32'(ed));
    endtask

    initial begin
        rst_n = 1'b0;
        {a_clr, a_push, a_pop, a_ec} = '0;
        {b_clr, b_push, b_pop, b_ec} = '0;
        a_pd = '0;
        b_pd = '0;

        for (int i = 0; i < 16; i++) tv.push_back(mk(1, 0, 0, 0, 32'(i), i + 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 32'hDEAD, 16, 1, 0));
        tv.push_back(mk(0, 0, 0, 1, 32'h0, 16, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 32'hBEEF, 16, 0, 0));
        for (int k = 0; k < 16; k++) tv.push_back(mk(0, 1, 0, 0, 32'h0, 15 - k, 0, 0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 1, 32'h0, 0, 0, 0));
        tv.push_back(mk(1, 1, 0, 0, 32'h55, 1, 0, 1));
        tv.push_back(mk(0, 1, 0, 0, 32'h0, 0, 0, 1));
        for (int k = 0; k < 5; k++) tv.push_back(mk(1, 0, 0, 0, 32'(256 + k), k + 1, 0, 1));
        tv.push_back(mk(1, 0, 1, 0, 32'h77, 0, 0, 1));
        tv.push_back(mk(1, 0, 0, 0, 32'h88, 1, 0, 1));
        tv.push_back(mk(0, 1, 0, 1, 32'h0, 0, 0, 0));
        tv.push_back(mk(0, 1, 0, 1, 32'h0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 1, 32'h0, 0, 0, 0));
        for (int k = 0; k < 3; k++) tv.push_back(mk(1, 0, 0, 0, 32'(768 + k), k + 1, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("a_rst_count", 32'(a_cnt), 32'd0);
        chk("a_rst_flags",
            32'({a_full, a_afull, a_empty, a_aempty, a_ovf, a_udf, a_pv}),
            32'b0011000);
        chk("b_rst_flags",
            32'({b_full, b_afull, b_empty, b_aempty, b_ovf, b_udf, b_pv}),
            32'b0011000);
        chk("b_rst_data", 32'(b_qd), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) step_a(tv[i], i);
        @(negedge clk);
        {a_push, a_pop, a_ec} = '0;

        step_b(1, 8'hA1, 0);
        step_b(1, 8'hA2, 0);
        step_b(0, 8'h00, 1);
        step_b(0, 8'h00, 0);
        chk("b_hold", 32'(b_qd), 32'hA1);
        step_b(0, 8'h00, 1);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) step_b(1, 8'(16 * r + k + 1), 0);
            chk("b_full", 32'({b_full, b_cnt}), 32'b1100);
            for (int k = 0; k < 4; k++) step_b(0, 8'h00, 1);
        end
        chk("b_empty", 32'(b_empty), 32'd1);
        for (int k = 0; k < 5; k++) step_b(1, 8'(k + 64), 0);
        step_b(0, 8'h00, 0);
        chk("b_ovf", 32'({b_ovf, b_cnt}), 32'b1100);

        @(negedge clk);
        rst_n = 1'b0;
        a_push = 1'b1; a_pd = 32'h999;
        b_push = 1'b1; b_pd = 8'h99;
        @(posedge clk);
        #1;
        chk("a_midrst_count", 32'(a_cnt), 32'd0);
        chk("a_midrst_flags",
            32'({a_full, a_afull, a_empty, a_aempty, a_ovf, a_udf, a_pv}),
            32'b0011000);
        chk("b_midrst",
            32'({b_qd, b_pv, b_cnt, b_ovf, b_empty}),
            32'({8'h00, 1'b0, 3'd0, 1'b0, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;
        a_push = 1'b0;
        b_push = 1'b0;
        @(posedge clk);
        #1;
        chk("a_after_rst", 32'({a_cnt, a_empty}), 32'b000001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
